// File: rtl/spi_mem_sequencer.sv
// -----------------------------------------------------------------------------
// spi_mem_sequencer
//
// Transaction sequencer for the SPI-slave memory datapath. It watches the
// conditioned chip select and the one-cycle SCLK edge strobes. It counts the
// address header, the R/W bit and the data bits. It issues the one-cycle
// load/write pulses for the address latch, the shift register and the data
// memory. It also drives the MISO tri-state enable.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   cs_n        conditioned chip select, active low
//   sclk_pos    one-clk strobe on a conditioned SCLK rising edge
//   sclk_neg    one-clk strobe on a conditioned SCLK falling edge
//   sr_lsb      shift register bit 0 (holds the R/W bit after the header)
//   addr_we     address latch load pulse
//   sr_we       shift register parallel-load pulse (memory read data)
//   dm_we       data memory write pulse
//   miso_bufe   MISO tri-state enable
//   busy        high whenever the sequencer is not idle
//   xfer_done   one-clk pulse when a read or write completes
//   xfer_abort  one-clk pulse when chip select is released mid-frame
//
// Every output is a flop. Each output's next value is decided together with
// the state transition that produces it.
// -----------------------------------------------------------------------------
module spi_mem_sequencer #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic sr_lsb,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_bufe,
    output logic busy,
    output logic xfer_done,
    output logic xfer_abort
);

    localparam int CNT_MAX = (ADDR_BITS + 1 > DATA_BITS) ? ADDR_BITS + 1 : DATA_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // The counter still holds the count of earlier edges while the final edge
    // is being seen. The terminal compares therefore use count-1.
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DECODE,
        S_READ_LOAD,
        S_READ_SHIFT,
        S_WRITE,
        S_COMMIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;

    logic addr_we_q,    addr_we_d;
    logic sr_we_q,      sr_we_d;
    logic dm_we_q,      dm_we_d;
    logic miso_bufe_q,  miso_bufe_d;
    logic busy_q,       busy_d;
    logic xfer_done_q,  xfer_done_d;
    logic xfer_abort_q, xfer_abort_d;

    logic neg_only;
    logic abortable;

    // A falling-edge strobe that coincides with a rising-edge strobe is dropped.
    assign neg_only  = sclk_neg & ~sclk_pos;

    // Chip select may be released without an abort in IDLE, COMMIT and DONE.
    assign abortable = state_q inside {S_HEADER, S_DECODE, S_READ_LOAD,
                                       S_READ_SHIFT, S_WRITE};

    always_comb begin
        state_d      = state_q;
        cnt_inc      = 1'b0;
        addr_we_d    = 1'b0;
        sr_we_d      = 1'b0;
        dm_we_d      = 1'b0;
        miso_bufe_d  = 1'b0;
        xfer_done_d  = 1'b0;
        xfer_abort_d = 1'b0;

        if (cs_n && abortable) begin
            // Abort takes priority over any strobe in the same cycle. This
            // also covers a final write edge, so an aborted frame never commits.
            state_d      = S_IDLE;
            xfer_abort_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!cs_n) begin
                        state_d = S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (sclk_pos) begin
                        cnt_inc = 1'b1;
                        if (cnt_q == HDR_LAST) begin
                            state_d   = S_DECODE;
                            addr_we_d = 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    state_d = sr_lsb ? S_READ_LOAD : S_WRITE;
                end
                S_READ_LOAD: begin
                    if (neg_only) begin
                        state_d = S_READ_SHIFT;
                        sr_we_d = 1'b1;
                    end
                end
                S_READ_SHIFT: begin
                    miso_bufe_d = 1'b1;
                    if (sclk_pos) begin
                        cnt_inc = 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            state_d     = S_DONE;
                            miso_bufe_d = 1'b0;
                            xfer_done_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (sclk_pos) begin
                        cnt_inc = 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            state_d     = S_COMMIT;
                            dm_we_d     = 1'b1;
                            xfer_done_d = 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (cs_n) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Every state begins counting from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_we_q    <= 1'b0;
            sr_we_q      <= 1'b0;
            dm_we_q      <= 1'b0;
            miso_bufe_q  <= 1'b0;
            busy_q       <= 1'b0;
            xfer_done_q  <= 1'b0;
            xfer_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_we_q    <= addr_we_d;
            sr_we_q      <= sr_we_d;
            dm_we_q      <= dm_we_d;
            miso_bufe_q  <= miso_bufe_d;
            busy_q       <= busy_d;
            xfer_done_q  <= xfer_done_d;
            xfer_abort_q <= xfer_abort_d;
        end
    end

    assign addr_we    = addr_we_q;
    assign sr_we      = sr_we_q;
    assign dm_we      = dm_we_q;
    assign miso_bufe  = miso_bufe_q;
    assign busy       = busy_q;
    assign xfer_done  = xfer_done_q;
    assign xfer_abort = xfer_abort_q;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_sequencer
//
// The bench builds cycle-by-cycle stimulus tables of SPI frames. Some frames
// are directed and some are random. From each table it derives the expected
// output pulses at frame level. It locates the header, decode, data and done
// phases by scanning the table for edge counts and chip-select changes. It then
// drives the table into the sequencer and compares all outputs on every clock.
// -----------------------------------------------------------------------------
module tb_spi_mem_sequencer;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;
    localparam int MAXC      = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic cs_n;
    logic sclk_pos;
    logic sclk_neg;
    logic sr_lsb;
    logic addr_we, sr_we, dm_we, miso_bufe, busy, xfer_done, xfer_abort;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus table and expected outputs after each clock edge.
    bit s_cs  [MAXC];
    bit s_pos [MAXC];
    bit s_neg [MAXC];
    bit s_lsb [MAXC];
    bit e_addr[MAXC];
    bit e_sr  [MAXC];
    bit e_dm  [MAXC];
    bit e_miso[MAXC];
    bit e_busy[MAXC];
    bit e_done[MAXC];
    bit e_abrt[MAXC];
    int len = 0;

    logic [6:0] dut_vec;
    assign dut_vec = {addr_we, sr_we, dm_we, miso_bufe, busy, xfer_done, xfer_abort};

    spi_mem_sequencer #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .sclk_pos   (sclk_pos),
        .sclk_neg   (sclk_neg),
        .sr_lsb     (sr_lsb),
        .addr_we    (addr_we),
        .sr_we      (sr_we),
        .dm_we      (dm_we),
        .miso_bufe  (miso_bufe),
        .busy       (busy),
        .xfer_done  (xfer_done),
        .xfer_abort (xfer_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got {addr,sr,dm,miso,busy,done,abort}=%07b expected %07b",
                     tag, got, exp);
        end
    endtask

    // ---------------- stimulus construction ----------------
    task automatic push(input bit cs, input bit pos, input bit neg, input bit lsb);
        if (len < MAXC) begin
            s_cs[len]  = cs;
            s_pos[len] = pos;
            s_neg[len] = neg;
            s_lsb[len] = lsb;
            len++;
        end
    endtask

    task automatic gap(input int n, input bit lsb);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, lsb);
    endtask

    // Chip select is released, with random SCLK noise that must be ignored.
    task automatic tail(input int n);
        for (int i = 0; i < n; i++)
            push(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    endtask

    // hdr: header edges before cs_n rises (ADDR_BITS+1 for a full header).
    // ndata: data edges; fewer than DATA_BITS ends the frame in an abort.
    // race: cs_n rises together with the last data edge.
    task automatic frame(input bit rw, input int hdr, input int ndata, input bit race,
                         input bit collide, input int extra, input int tl);
        push(1'b0, 1'b0, 1'b0, rw);
        for (int i = 0; i < hdr; i++) begin
            gap($urandom_range(0, 2), rw);
            push(1'b0, 1'b1, 1'b0, rw);
        end
        if (hdr < ADDR_BITS + 1) begin
            push(1'b1, 1'b0, 1'b0, rw);
            tail(tl);
            return;
        end
        gap(1 + $urandom_range(0, 1), rw);
        if (rw) begin
            if (collide) begin
                push(1'b0, 1'b1, 1'b1, rw);
                gap($urandom_range(0, 1), rw);
            end
            push(1'b0, 1'b0, 1'b1, rw);
        end
        for (int i = 0; i < ndata; i++) begin
            gap($urandom_range(0, 2), rw);
            push(race && (i == ndata - 1), 1'b1, 1'b0, rw);
        end
        if (!race && ndata < DATA_BITS) begin
            push(1'b1, 1'b0, 1'b0, rw);
        end else if (!race) begin
            for (int i = 0; i < extra; i++) begin
                gap($urandom_range(0, 2), rw);
                push(1'b0, 1'b1, 1'($urandom_range(0, 1)), rw);
            end
        end
        tail(tl);
    endtask

    // cs_n rises in the cycle right after the last header edge (decode phase).
    task automatic decode_abort();
        push(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < ADDR_BITS + 1; i++) push(1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        tail(1);
    endtask

    // ---------------- reference model ----------------
    // Scan forward from 'from' until 'need' qualifying edges are seen or cs_n
    // rises. Busy is marked on the cycles that stay inside the frame.
    task automatic seek(input int from, input int need, input bit want_neg,
                        input bit mark_miso, output int at, output bit ab);
        int n;
        n  = 0;
        ab = 1'b0;
        at = len;
        for (int j = from; j < len; j++) begin
            if (s_cs[j]) begin
                e_abrt[j] = 1'b1;
                ab = 1'b1;
                at = j;
                return;
            end
            e_busy[j] = 1'b1;
            if (want_neg ? (s_neg[j] && !s_pos[j]) : s_pos[j]) n++;
            if (n == need) begin
                at = j;
                return;
            end
            if (mark_miso) e_miso[j] = 1'b1;
        end
    endtask

    task automatic build_expect();
        int  p, k, h, d, r, u, w, dn, j;
        bit  ab;
        for (int i = 0; i < len; i++) begin
            e_addr[i] = 0; e_sr[i] = 0; e_dm[i] = 0; e_miso[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_abrt[i] = 0;
        end
        p = 0;
        while (p < len) begin
            k = p;
            while (k < len && s_cs[k]) k++;
            if (k >= len) break;
            e_busy[k] = 1'b1;
            seek(k + 1, ADDR_BITS + 1, 1'b0, 1'b0, h, ab);
            if (h >= len) break;
            if (ab) begin p = h + 1; continue; end
            e_addr[h] = 1'b1;
            d = h + 1;
            if (d >= len) break;
            if (s_cs[d]) begin
                e_abrt[d] = 1'b1;
                p = d + 1;
                continue;
            end
            e_busy[d] = 1'b1;
            if (s_lsb[d]) begin
                seek(d + 1, 1, 1'b1, 1'b0, r, ab);
                if (r >= len) break;
                if (ab) begin p = r + 1; continue; end
                e_sr[r] = 1'b1;
                seek(r + 1, DATA_BITS, 1'b0, 1'b1, u, ab);
                if (u >= len) break;
                if (ab) begin p = u + 1; continue; end
                e_done[u] = 1'b1;
                dn = u + 1;
            end else begin
                seek(d + 1, DATA_BITS, 1'b0, 1'b0, w, ab);
                if (w >= len) break;
                if (ab) begin p = w + 1; continue; end
                e_dm[w]   = 1'b1;
                e_done[w] = 1'b1;
                if (w + 1 >= len) break;
                e_busy[w + 1] = 1'b1;   // commit cycle ignores cs_n
                dn = w + 2;
            end
            j = dn;
            while (j < len && !s_cs[j]) begin
                e_busy[j] = 1'b1;
                j++;
            end
            p = j + 1;
        end
    endtask

    function automatic logic [6:0] exp_vec(input int i);
        return {e_addr[i], e_sr[i], e_dm[i], e_miso[i], e_busy[i], e_done[i], e_abrt[i]};
    endfunction

    task automatic run_segment(input string name);
        build_expect();
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cs_n     = s_cs[i];
            sclk_pos = s_pos[i];
            sclk_neg = s_neg[i];
            sr_lsb   = s_lsb[i];
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", name, i), dut_vec, exp_vec(i));
        end
        len = 0;
    endtask

    initial begin
        int kind;
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        sr_lsb   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec, 7'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frames: write, read with strobe collision plus extra
        // edges in done, abort after 5 data edges, final-edge race,
        // back-to-back read, decode abort, header abort.
        len = 0;
        tail(2);
        frame(1'b0, ADDR_BITS + 1, DATA_BITS, 1'b0, 1'b0, 0, 2);
        frame(1'b1, ADDR_BITS + 1, DATA_BITS, 1'b0, 1'b1, 3, 2);
        frame(1'b0, ADDR_BITS + 1, 5, 1'b0, 1'b0, 0, 1);
        frame(1'b0, ADDR_BITS + 1, DATA_BITS, 1'b1, 1'b0, 0, 1);
        frame(1'b1, ADDR_BITS + 1, DATA_BITS, 1'b0, 1'b0, 1, 1);
        decode_abort();
        frame(1'b0, 3, 0, 1'b0, 1'b0, 0, 2);
        run_segment("directed");

        // Random frame mix.
        for (int f = 0; f < 16; f++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: frame(1'b0, ADDR_BITS + 1, DATA_BITS, 1'b0, 1'b0,
                         $urandom_range(0, 3), $urandom_range(1, 3));
                1: frame(1'b1, ADDR_BITS + 1, DATA_BITS, 1'b0, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3), $urandom_range(1, 3));
                2: frame(1'b0, ADDR_BITS + 1, $urandom_range(0, DATA_BITS - 1), 1'b0, 1'b0,
                         0, $urandom_range(1, 3));
                3: frame(1'b1, ADDR_BITS + 1, $urandom_range(0, DATA_BITS - 1), 1'b0,
                         1'($urandom_range(0, 1)), 0, $urandom_range(1, 3));
                4: frame(1'b0, ADDR_BITS + 1, DATA_BITS, 1'b1, 1'b0, 0, $urandom_range(1, 3));
                default: frame(1'($urandom_range(0, 1)), $urandom_range(0, ADDR_BITS), 0,
                               1'b0, 1'b0, 0, $urandom_range(1, 3));
            endcase
        end
        run_segment("random");

        // Read frame stopped partway through the data phase, then reset.
        len = 0;
        push(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < ADDR_BITS + 1; i++) begin
            push(1'b0, 1'b0, 1'b0, 1'b1);
            push(1'b0, 1'b1, 1'b0, 1'b1);
        end
        gap(1, 1'b1);
        push(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            gap(1, 1'b1);
            push(1'b0, 1'b1, 1'b0, 1'b1);
        end
        gap(1, 1'b1);
        run_segment("read_partial");
        chk("miso_before_rst", {6'b0, miso_bufe}, 7'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("outputs_in_async_rst", dut_vec, 7'b0);
        @(negedge clk);
        cs_n     = 1'b1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        len = 0;
        tail(1);
        frame(1'b0, ADDR_BITS + 1, DATA_BITS, 1'b0, 1'b0, 0, 2);
        run_segment("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_sequencer.md
Name: spi_mem_sequencer

Overview:
- Single-clock transaction sequencer for the SPI-slave memory datapath: shift register, address latch, data memory and MISO tri-state buffer.
- Consumes conditioned chip-select plus one-cycle SCLK edge strobes from the input conditioners.
- Counts address, R/W and data bits exactly, and issues one-cycle load/write pulses plus the MISO buffer enable.
- Handles CS abort mid-frame and reports transaction completion to the rest of the design.

Parameters:
- ADDR_BITS, 7, address bits shifted in before the R/W bit
- DATA_BITS, 8, data bits per read or write phase

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- cs_n  input  1  conditioned chip select, active low
- sclk_pos  input  1  one-clk strobe on conditioned SCLK rising edge
- sclk_neg  input  1  one-clk strobe on conditioned SCLK falling edge
- sr_lsb  input  1  shift register parallel-out bit 0 (R/W bit after header)
- addr_we  output  1  address latch load pulse
- sr_we  output  1  shift register parallel-load pulse (memory read data)
- dm_we  output  1  data memory write pulse
- miso_bufe  output  1  MISO tri-state enable
- busy  output  1  high in any state except IDLE
- xfer_done  output  1  one-clk pulse on completed read or write
- xfer_abort  output  1  one-clk pulse when CS deasserts mid-frame

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state IDLE, bit counter 0, all outputs 0.
- All outputs are registered. Pulses are exactly one clk wide.
- Bit counter width: clog2(max(ADDR_BITS+1, DATA_BITS))+1. Cleared on every state entry.
- Strobe rule: if sclk_pos and sclk_neg are both high in one cycle, sclk_pos wins and sclk_neg is ignored.
- States:
  - IDLE: cs_n==0 -> HEADER.
  - HEADER: each sclk_pos increments the counter. On the (ADDR_BITS+1)th sclk_pos -> DECODE.
  - DECODE (1 clk): addr_we=1. sr_lsb==1 -> READ_LOAD; sr_lsb==0 -> WRITE.
  - READ_LOAD: wait for sclk_neg. On it: sr_we=1 for one clk, miso_bufe=1 from the next clk, -> READ_SHIFT.
  - READ_SHIFT: miso_bufe held 1. Count DATA_BITS sclk_pos. On the last one: xfer_done=1, miso_bufe=0 the next clk, -> DONE.
  - WRITE: count DATA_BITS sclk_pos. On the last one -> COMMIT.
  - COMMIT (1 clk): dm_we=1, xfer_done=1, -> DONE.
  - DONE: outputs 0, busy=1. Extra SCLK edges are ignored. cs_n==1 -> IDLE.
- Abort: cs_n==1 in HEADER, DECODE, READ_LOAD, READ_SHIFT or WRITE:
  - next clk -> IDLE, xfer_abort=1;
  - miso_bufe, sr_we and addr_we are 0 in that cycle;
  - no dm_we is ever issued for an aborted frame.
- Abort priority: cs_n rising in the same clk as the final WRITE sclk_pos means abort wins. No COMMIT, no dm_we.
- COMMIT completes regardless of cs_n. If cs_n is already high, DONE exits to IDLE on the following clk.
- cs_n==1 in IDLE or DONE: not an abort.
- Back-to-back frames: cs_n low again in the clk after reaching IDLE starts a new HEADER. The counter is 0 on entry.
- rst_n low mid-operation: immediate IDLE, all outputs 0, no pulses emitted.

Test Plan:
- Write frame: cs_n low, 8 sclk_pos with header 0xA4 (addr 0x52, RW=0), then 8 data edges -> addr_we pulse once after edge 8; dm_we and xfer_done pulse once, 1 clk after data edge 8; miso_bufe stays 0.
- Read frame: header 0xA5 (RW=1), then sclk_neg -> addr_we pulse; sr_we pulse on that sclk_neg clk; miso_bufe 1 from the next clk through the 8th data sclk_pos; xfer_done pulse; dm_we never high.
- Abort: cs_n high after 5 write data edges -> xfer_abort pulse next clk; state IDLE; dm_we never asserted; busy 0.
- Race: cs_n rises in the same clk as the 8th write data sclk_pos -> xfer_abort=1, dm_we=0.
- Reset mid-read: rst_n low while miso_bufe=1 -> all outputs 0 immediately (asynchronous). After release, a fresh write frame completes normally.
- Strobe collision plus extra edges: sclk_pos and sclk_neg high together in READ_LOAD -> no sr_we that cycle. 3 extra sclk_pos in DONE -> no outputs change until cs_n goes high.
